// File: rtl/mxu_pkg.sv
// Shared definitions for the systolic matrix unit host interface.
//   region_e    : address region decoded from addr[13:12]
//   RESP_*      : AXI response codes
//   CTRL_*_BIT  : bit positions inside the CTRL register
//   rd_state_e  : read channel state machine encoding
package mxu_pkg;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_A    = 2'd1,
    REG_B    = 2'd2,
    REG_RES  = 2'd3
  } region_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_BUSY_BIT  = 2;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/mxu_ctrl_reg.sv
// START/BUSY/DONE control state for the matrix unit.
//   clk, reset : clock, asynchronous active-high reset
//   start_set  : validated START request from the write execute cycle
//   done_clr   : DONE write-one-to-clear from the write execute cycle
//   done_in    : completion pulse from the array controller
//   start      : one-cycle start pulse (same cycle as start_set)
//   busy, done : registered status bits
module mxu_ctrl_reg (
  input  logic clk,
  input  logic reset,
  input  logic start_set,
  input  logic done_clr,
  input  logic done_in,
  output logic start,
  output logic busy,
  output logic done
);

  // start_set is only raised while idle, so the pulse is a direct pass-through.
  assign start = start_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (start_set)    busy <= 1'b1;
      else if (done_in) busy <= 1'b0;

      // A completion arriving together with a clear must not be lost.
      if (done_in)                    done <= 1'b1;
      else if (start_set || done_clr) done <= 1'b0;
    end
  end

endmodule

// File: rtl/mxu_axil_slave.sv
// AXI4-Lite slave front-end for the systolic matrix unit.
//   clk, reset          : clock, asynchronous active-high reset
//   aw*/w*/b*           : AXI write channels (AW and W captured independently)
//   ar*/r*              : AXI read channels (fixed 2-cycle AR-to-R latency)
//   buf_we..buf_wstrb   : operand buffer write port (A when buf_sel=0, B when 1)
//   start, done_in      : start pulse out, completion pulse in
//   res_idx, res_data   : result element select / returned element
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and once raised stays high until
// that transfer.
module mxu_axil_slave
  import mxu_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int ELEM_W = 8,
  parameter int RES_W  = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [ADDR_W-1:0]                            awaddr,
  input  logic                                         awvalid,
  output logic                                         awready,
  input  logic [DATA_W-1:0]                            wdata,
  input  logic [DATA_W/8-1:0]                          wstrb,
  input  logic                                         wvalid,
  output logic                                         wready,
  output logic [1:0]                                   bresp,
  output logic                                         bvalid,
  input  logic                                         bready,
  input  logic [ADDR_W-1:0]                            araddr,
  input  logic                                         arvalid,
  output logic                                         arready,
  output logic [DATA_W-1:0]                            rdata,
  output logic [1:0]                                   rresp,
  output logic                                         rvalid,
  input  logic                                         rready,
  output logic                                         buf_we,
  output logic                                         buf_sel,
  output logic [$clog2(SIZE*SIZE*ELEM_W/DATA_W)-1:0]   buf_addr,
  output logic [DATA_W-1:0]                            buf_wdata,
  output logic [DATA_W/8-1:0]                          buf_wstrb,
  output logic                                         start,
  input  logic                                         done_in,
  output logic [$clog2(SIZE*SIZE)-1:0]                 res_idx,
  input  logic [RES_W-1:0]                             res_data
);

  localparam int unsigned OP_WORDS = SIZE * SIZE * ELEM_W / DATA_W;
  localparam int unsigned RES_N    = SIZE * SIZE;
  localparam int          BUF_AW   = $clog2(OP_WORDS);
  localparam int          RES_IW   = $clog2(RES_N);
  localparam int          STRB_W   = DATA_W / 8;

  // Only addr[13:2] carries meaning; the rest is ignored on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[ADDR_W-1:14], awaddr[1:0],
                              araddr[ADDR_W-1:14], araddr[1:0]};

  // ---------------------------------------------------------------- write path
  logic              aw_held, w_held;
  logic [13:2]       aw_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic    exec;
  region_e w_region;
  logic [9:0] w_idx;
  logic    wr_err, op_we, start_req, clr_req;
  logic    busy, done;

  assign awready  = !aw_held && !bvalid;
  assign wready   = !w_held && !bvalid;
  assign exec     = aw_held && w_held;
  assign w_region = region_e'(aw_addr_q[13:12]);
  assign w_idx    = aw_addr_q[11:2];

  // Decode of the held write; at most one side effect, none when erroring.
  always_comb begin
    wr_err    = 1'b0;
    op_we     = 1'b0;
    start_req = 1'b0;
    clr_req   = 1'b0;
    case (w_region)
      REG_CTRL: begin
        if (w_idx != 10'd0) begin
          wr_err = 1'b1;
        end else if (wstrb_q[0] && wdata_q[CTRL_START_BIT]) begin
          if (busy) wr_err    = 1'b1;
          else      start_req = 1'b1;
        end else if (wstrb_q[0] && wdata_q[CTRL_DONE_BIT]) begin
          clr_req = 1'b1;
        end
      end
      REG_A, REG_B: begin
        if (32'(w_idx) >= OP_WORDS || busy) wr_err = 1'b1;
        else                                 op_we  = 1'b1;
      end
      default: wr_err = 1'b1;
    endcase
  end

  assign buf_we    = exec && op_we;
  assign buf_sel   = (w_region == REG_B);
  assign buf_addr  = w_idx[BUF_AW-1:0];
  assign buf_wdata = wdata_q;
  assign buf_wstrb = wstrb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
    end else begin
      if (awvalid && awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr[13:2];
      end
      if (wvalid && wready) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      // Readies are low during execute, so clearing here never races a capture.
      if (exec) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  mxu_ctrl_reg u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start_set (exec && start_req),
    .done_clr  (exec && clr_req),
    .done_in   (done_in),
    .start     (start),
    .busy      (busy),
    .done      (done)
  );

  // ----------------------------------------------------------------- read path
  rd_state_e         rd_state, rd_state_n;
  logic [13:2]       ar_addr_q;
  region_e           rd_region;
  logic [9:0]        rd_idx;
  logic [DATA_W-1:0] rd_word;
  logic [1:0]        rd_resp;

  assign arready   = (rd_state == R_IDLE);
  assign rvalid    = (rd_state == R_DATA);
  assign rd_region = region_e'(ar_addr_q[13:12]);
  assign rd_idx    = ar_addr_q[11:2];

  always_comb begin
    rd_state_n = rd_state;
    case (rd_state)
      R_IDLE:  if (arvalid) rd_state_n = R_WAIT;
      R_WAIT:  rd_state_n = R_DATA;
      R_DATA:  if (rready) rd_state_n = R_IDLE;
      default: rd_state_n = R_IDLE;
    endcase
  end

  // Read data is formed in R_WAIT, giving res_data one cycle after res_idx.
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_region)
      REG_CTRL: begin
        if (rd_idx != 10'd0) begin
          rd_resp = RESP_SLVERR;
        end else begin
          rd_word[CTRL_DONE_BIT] = done;
          rd_word[CTRL_BUSY_BIT] = busy;
        end
      end
      REG_A, REG_B: begin
        // Operand buffers are write-only; in-range reads return zero.
        if (32'(rd_idx) >= OP_WORDS) rd_resp = RESP_SLVERR;
      end
      default: begin
        if (32'(rd_idx) >= RES_N) rd_resp = RESP_SLVERR;
        else                      rd_word[RES_W-1:0] = res_data;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state  <= R_IDLE;
      ar_addr_q <= '0;
      res_idx   <= '0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
    end else begin
      rd_state <= rd_state_n;
      if (rd_state == R_IDLE && arvalid) begin
        ar_addr_q <= araddr[13:2];
        res_idx   <= araddr[2 +: RES_IW];
      end
      if (rd_state == R_WAIT) begin
        rdata <= rd_word;
        rresp <= rd_resp;
      end
    end
  end

endmodule

// File: tb/tb_mxu_axil_slave.sv
// Directed bench for mxu_axil_slave with default parameters
// (SIZE=16, ELEM_W=8, RES_W=32, DATA_W=32, ADDR_W=16).
module tb_mxu_axil_slave;
  import mxu_pkg::*;

  // ------------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic        buf_we, buf_sel, start, done_in;
  logic [5:0]  buf_addr;
  logic [31:0] buf_wdata;
  logic [3:0]  buf_wstrb;
  logic [7:0]  res_idx;
  logic [31:0] res_data;

  mxu_axil_slave dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .buf_we(buf_we), .buf_sel(buf_sel), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_wstrb(buf_wstrb),
    .start(start), .done_in(done_in),
    .res_idx(res_idx), .res_data(res_data)
  );

  // --------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [42:0] exp_buf_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endtask

  function automatic logic [42:0] buf_exp(input logic sel, input logic [5:0] a,
                                          input logic [31:0] d, input logic [3:0] s);
    return {sel, a, d, s};
  endfunction

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (exp_b_q.size() == 0) unexpected("b_resp");
      else check("bresp", bresp, exp_b_q.pop_front());
    end
    if (rvalid && rready) begin
      if (exp_r_q.size() == 0) unexpected("r_resp");
      else check("rresp_rdata", {rresp, rdata}, exp_r_q.pop_front());
    end
    if (buf_we) begin
      if (exp_buf_q.size() == 0) unexpected("buf_we");
      else check("buf_write", {buf_sel, buf_addr, buf_wdata, buf_wstrb}, exp_buf_q.pop_front());
    end
    if (start) start_cnt++;
  end

  // ------------------------------------------------------------ driver tasks
  task automatic send_aw(input logic [15:0] a, input int dly);
    bit ok = 0;
    repeat (dly) @(posedge clk);
    #1 awaddr = a; awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    check("aw_handshake", ok, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit ok = 0;
    repeat (dly) @(posedge clk);
    #1 wdata = d; wstrb = s; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    check("w_handshake", ok, 1);
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic wait_bvalid();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; break; end
    end
    check("b_wait", ok, 1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int hold,
                          input logic [1:0] resp);
    exp_b_q.push_back(resp);
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    wait_bvalid();
    repeat (hold) begin
      @(negedge clk);
      check("bvalid_hold", bvalid, 1);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic ar_handshake(input logic [15:0] a);
    bit ok = 0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    check("ar_handshake", ok, 1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [1:0] resp, input logic [31:0] d,
                         input logic [7:0] exp_idx, input int hold);
    exp_r_q.push_back({resp, d});
    ar_handshake(a);
    @(negedge clk);
    check("rvalid_cycle1", rvalid, 0);
    check("res_idx", res_idx, exp_idx);
    @(negedge clk);
    check("rvalid_cycle2", rvalid, 1);
    repeat (hold) begin
      @(negedge clk);
      check("rvalid_hold", rvalid, 1);
      check("rdata_stable", rdata, d);
    end
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done_in = 1'b1;
    @(posedge clk); #1 done_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ----------------------------------------------------------------- stimulus
  initial begin
    reset = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; done_in = 0;
    res_data = 32'h12345678;
    #2;
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_buf_we", buf_we, 0);
    check("rst_start", start, 0);
    check("rst_res_idx", res_idx, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("idle_awready", awready, 1);
    check("idle_wready", wready, 1);
    check("idle_arready", arready, 1);

    // Operand A, AW two cycles ahead of W, response held off for 3 cycles.
    exp_buf_q.push_back(buf_exp(1'b0, 6'd1, 32'hDDCCBBAA, 4'b0101));
    do_write(16'h1004, 32'hDDCCBBAA, 4'b0101, 0, 2, 3, RESP_OKAY);
    // Operand B, W ahead of AW.
    exp_buf_q.push_back(buf_exp(1'b1, 6'd0, 32'h11223344, 4'hF));
    do_write(16'h2000, 32'h11223344, 4'hF, 2, 0, 0, RESP_OKAY);
    // Index 64 is one past the last operand word.
    do_write(16'h2100, 32'h0BADF00D, 4'hF, 0, 0, 0, RESP_SLVERR);
    // Index 63 is the last operand word.
    exp_buf_q.push_back(buf_exp(1'b0, 6'd63, 32'h0000BEEF, 4'b0011));
    do_write(16'h10FC, 32'h0000BEEF, 4'b0011, 1, 1, 0, RESP_OKAY);
    do_write(16'h3000, 32'h1, 4'hF, 0, 0, 0, RESP_SLVERR);
    do_write(16'h0004, 32'h1, 4'hF, 0, 0, 0, RESP_SLVERR);
    check("no_start_yet", start_cnt, 0);

    do_read(16'h1008, RESP_OKAY,   32'h0, 8'd2, 0);
    do_read(16'h0008, RESP_SLVERR, 32'h0, 8'd2, 0);
    do_read(16'h0000, RESP_OKAY,   32'h0, 8'd0, 0);

    // START from idle, then BUSY-guarded writes.
    do_write(16'h0000, 32'h1, 4'hF, 0, 0, 0, RESP_OKAY);
    check("start_once", start_cnt, 1);
    do_read(16'h0000, RESP_OKAY, 32'h4, 8'd0, 0);
    do_write(16'h0000, 32'h1, 4'hF, 0, 0, 0, RESP_SLVERR);
    check("start_busy_no_pulse", start_cnt, 1);
    do_write(16'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, RESP_SLVERR);

    pulse_done();
    do_read(16'h0000, RESP_OKAY, 32'h2, 8'd0, 0);

    // DONE W1C executing in the same cycle as done_in: the set wins.
    fork
      do_write(16'h0000, 32'h2, 4'hF, 0, 0, 0, RESP_OKAY);
      begin
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (awvalid && awready) begin seen = 1; break; end
        end
        check("coincide_aw_seen", seen, 1);
        @(posedge clk); #1 done_in = 1'b1;
        @(posedge clk); #1 done_in = 1'b0;
      end
    join
    do_read(16'h0000, RESP_OKAY, 32'h2, 8'd0, 0);
    do_write(16'h0000, 32'h2, 4'hF, 0, 0, 0, RESP_OKAY);
    do_read(16'h0000, RESP_OKAY, 32'h0, 8'd0, 0);

    // Result readback.
    do_read(16'h3010, RESP_OKAY, 32'h12345678, 8'd4, 4);
    do_read(16'h3400, RESP_SLVERR, 32'h0, 8'd0, 0);
    res_data = 32'h000000A5;
    do_read(16'h33FC, RESP_OKAY, 32'h000000A5, 8'd255, 0);

    // Reset while a B response is pending and the read FSM is in R_WAIT.
    exp_buf_q.push_back(buf_exp(1'b0, 6'd0, 32'hCAFEF00D, 4'hF));
    fork
      send_aw(16'h1000, 0);
      send_w(32'hCAFEF00D, 4'hF, 0);
    join
    wait_bvalid();
    @(posedge clk); #1;
    ar_handshake(16'h3010);
    reset = 1'b1;
    #1;
    check("mid_rst_bvalid", bvalid, 0);
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_start", start, 0);
    check("mid_rst_res_idx", res_idx, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_arready", arready, 1);
    check("post_rst_start_cnt", start_cnt, 1);
    exp_buf_q.push_back(buf_exp(1'b0, 6'd0, 32'h55AA55AA, 4'b0011));
    do_write(16'h1000, 32'h55AA55AA, 4'b0011, 0, 0, 0, RESP_OKAY);

    repeat (4) @(posedge clk);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);
    check("buf_queue_drained", exp_buf_q.size(), 0);
    check("final_start_cnt", start_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mxu_axil_slave.md
Name: mxu_axil_slave

Overview:
- Parametrised AXI4-Lite slave front-end for the systolic matrix unit; the next generation of the host interface block.
- Provides independent AW/W capture, a real B channel, byte-strobed writes into operand buffers A and B, a start/done/busy control register, and latency-fixed result readback.
- Sits between the host interconnect and the array/control pair. It drives buffer-write, start and result-select strobes, and receives done and result data.

Parameters:
- SIZE, 16: array dimension; matrices are SIZE x SIZE.
- ELEM_W, 8: operand element width in bits.
- RES_W, 32: result element width in bits; must be ≤ DATA_W.
- DATA_W, 32: AXI data width; must be a multiple of ELEM_W.
- ADDR_W, 16: AXI address width; must be ≥ 14.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- awaddr  in  ADDR_W  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte strobes
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response (00 OKAY, 10 SLVERR)
- bvalid  out  1  write response valid
- bready  in  1  write response ready
- araddr  in  ADDR_W  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- buf_we  out  1  one-cycle operand buffer write strobe
- buf_sel  out  1  operand buffer select (0 = A, 1 = B)
- buf_addr  out  $clog2(SIZE*SIZE*ELEM_W/DATA_W)  operand word index
- buf_wdata  out  DATA_W  operand write data
- buf_wstrb  out  DATA_W/8  operand byte enables
- start  out  1  one-cycle start pulse to control
- done_in  in  1  one-cycle completion pulse from control
- res_idx  out  $clog2(SIZE*SIZE)  result element select
- res_data  in  RES_W  result element; valid one cycle after res_idx changes

Behaviour:
- Address map: region = addr[13:12], word index = addr[11:2].
  - Region 0 is CTRL at word 0: bit0 START (W1S), bit1 DONE (RO sticky, W1C), bit2 BUSY (RO). Other words in region 0 are unmapped.
  - Region 1 is operand A; region 2 is operand B; region 3 is the result (read-only).
- Reset (async): bvalid=0, rvalid=0, bresp=rresp=00, rdata=0, buf_we=0, start=0, res_idx=0, busy=0, done=0, aw_held=w_held=0.
- Readies are combinational from registered state: awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
- AW and W are captured independently, in either order or in the same cycle, into holding registers.
- Execute cycle: the cycle after both are held. Decode, then perform at most one of: buf_we pulse (1 cycle), START set, DONE clear. Then set bvalid with the response and clear the held flags.
- bvalid holds until bready; the next AW/W can be accepted in the cycle after the B handshake.
- SLVERR with no side effect for any of:
  - write to result region;
  - unmapped CTRL word;
  - operand word index ≥ SIZE*SIZE*ELEM_W/DATA_W;
  - operand write while BUSY;
  - START=1 while BUSY.
- START=1 when idle: start pulses for exactly 1 cycle in the execute cycle; BUSY=1 and DONE=0 from the next cycle.
- done_in: BUSY=0 and DONE=1 next cycle. If done_in coincides with a DONE W1C, set wins (DONE=1).
- Read FSM:
  - R_IDLE: arready=1. On handshake, latch the address, drive res_idx from the word index, go to R_WAIT.
  - R_WAIT: 1 cycle. Capture rdata: CTRL value, operand read-back of 0 with OKAY (buffers are write-only), res_data zero-extended, or 0 with SLVERR for unmapped/out-of-range. Go to R_DATA.
  - R_DATA: rvalid=1 until rready, then R_IDLE.
  - Fixed latency: AR handshake to rvalid is 2 cycles.
- Read and write paths are fully independent; simultaneous read of CTRL and a write to CTRL returns the pre-write value.
- Reset mid-transaction discards everything held; no start pulse is emitted.

Decomposition:
- mxu_pkg holds:
  - region enum (REG_CTRL, REG_A, REG_B, REG_RES);
  - AXI response constants RESP_OKAY and RESP_SLVERR;
  - CTRL bit indices;
  - read FSM state enum.
- Natural sub-module: mxu_ctrl_reg, owning START/BUSY/DONE with set/clear priority and the start pulse.

Test Plan:
- AW two cycles before W, addr 0x1004, wdata 0xDDCCBBAA, wstrb 0101 -> buf_we=1 for 1 cycle, buf_sel=0, buf_addr=1, buf_wstrb=0101; bresp=00; bvalid held through 3 cycles of bready=0.
- W before AW, addr 0x2000 -> buf_sel=1, buf_addr=0. Then addr 0x2100 (index 64, SIZE=16) -> SLVERR, no buf_we.
- Write CTRL 0x1 -> start pulses once, CTRL read returns 0x4. A second START -> SLVERR, no pulse. Operand write while busy -> SLVERR. done_in pulse -> CTRL reads 0x2.
- DONE W1C write in the same cycle as done_in -> DONE remains 1; a following W1C clears it -> CTRL reads 0x0.
- Read 0x3010 with res_data=0x12345678 -> res_idx=4, rvalid exactly 2 cycles after AR handshake, rdata=0x12345678; hold rready=0 for 4 cycles -> rdata stable.
- Assert reset while bvalid=1 and the read FSM is in R_WAIT -> bvalid=rvalid=0 immediately, no start pulse; after release, a write to 0x1000 completes normally.
